inst_buffer: RTL and testbench

- Circular FIFO of FETCH_PACKETs between the fetch stage and the N decoders.
- Fetch enqueues up to N packets per cycle. Dispatch reads the oldest N entries combinationally and retires 0..N of them per cycle.
- Flushed on branch mispredict or other recovery.
- Its head outputs drive the decoders' inst_buffer_input ports directly.

---
 rtl/inst_buffer.sv | 97 +++++++++
 tb/tb_inst_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
`default_nettype none
// ============================================================================
// Module   : inst_buffer
// Brief    : Circular FIFO of fetch packets feeding N decoders; N-wide enqueue,
//            zero-latency N-wide head read, 0..N retire per cycle, flushable.
// Revision : 1.0 - initial release
// ============================================================================
module inst_buffer #(
    parameter int DEPTH = 8,
    parameter int N     = 2,
    parameter int PKT_W = 64
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [N-1:0][PKT_W-1:0]        in_packets,
    input  logic [$clog2(N+1)-1:0]         in_num_valid,
    input  logic [$clog2(N+1)-1:0]         dispatch_num,
    output logic [N-1:0][PKT_W-1:0]        out_packets,
    output logic [$clog2(N+1)-1:0]         out_num_valid,
    output logic [$clog2(DEPTH+1)-1:0]     free_slots
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int NUM_W = $clog2(N+1);

    logic [DEPTH-1:0][PKT_W-1:0] storage_q, storage_d;
    logic [PTR_W-1:0]            head_q, head_d;
    logic [PTR_W-1:0]            tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;

    logic [CNT_W-1:0]            free_w;
    logic [CNT_W-1:0]            in_num_w;
    logic [CNT_W-1:0]            disp_num_w;
    logic [CNT_W-1:0]            avail_w;
    logic [CNT_W-1:0]            accepted_w;
    logic [CNT_W-1:0]            removed_w;
    logic [NUM_W-1:0]            out_num_w;

    always_ff @(posedge clock) begin
        if (reset) begin
            storage_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            storage_q <= storage_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Occupancy-derived quantities; all based on pre-update state.
    always_comb begin
        free_w     = CNT_W'(DEPTH) - count_q;
        in_num_w   = CNT_W'(in_num_valid);
        disp_num_w = CNT_W'(dispatch_num);
        out_num_w  = (count_q >= CNT_W'(N)) ? NUM_W'(N) : count_q[NUM_W-1:0];
        avail_w    = CNT_W'(out_num_w);
        accepted_w = (in_num_w < free_w)    ? in_num_w   : free_w;
        removed_w  = (disp_num_w < avail_w) ? disp_num_w : avail_w;
    end

    always_comb begin
        storage_d = storage_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush) begin
            // Storage is left stale; only the pointers are rewound.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (CNT_W'(i) < accepted_w) begin
                    storage_d[tail_q + PTR_W'(i)] = in_packets[i];
                end
            end
            tail_d  = tail_q + accepted_w[PTR_W-1:0];
            head_d  = head_q + removed_w[PTR_W-1:0];
            count_d = count_q + accepted_w - removed_w;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            out_packets[i] = storage_q[head_q + PTR_W'(i)];
        end
        out_num_valid = out_num_w;
        free_slots    = free_w;
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_buffer
// Brief    : Directed bench for inst_buffer with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_buffer;

    localparam int DEPTH = 8;
    localparam int N     = 2;
    localparam int PKT_W = 64;

    logic                    clock;
    logic                    reset;
    logic                    flush;
    logic [N-1:0][PKT_W-1:0] in_packets;
    logic [1:0]              in_num_valid;
    logic [1:0]              dispatch_num;
    logic [N-1:0][PKT_W-1:0] out_packets;
    logic [1:0]              out_num_valid;
    logic [3:0]              free_slots;

    inst_buffer #(.DEPTH(DEPTH), .N(N), .PKT_W(PKT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .in_packets    (in_packets),
        .in_num_valid  (in_num_valid),
        .dispatch_num  (dispatch_num),
        .out_packets   (out_packets),
        .out_num_valid (out_num_valid),
        .free_slots    (free_slots)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [63:0] pkt(input logic [31:0] pc);
        return {~pc, pc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: plain FIFO queue updated at every active edge
    logic [PKT_W-1:0] mq[$];
    bit model_valid = 0;
    int m_acc, m_rem, m_free, m_avail;

    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            model_valid = 1;
        end else if (flush) begin
            mq.delete();
        end else begin
            m_free  = DEPTH - mq.size();
            m_avail = (mq.size() < N) ? mq.size() : N;
            m_acc   = (int'(in_num_valid) < m_free)  ? int'(in_num_valid) : m_free;
            m_rem   = (int'(dispatch_num) < m_avail) ? int'(dispatch_num) : m_avail;
            if (m_acc < int'(in_num_valid))
                $display("note: %0d packet(s) dropped, fetch protocol violation (t=%0t)",
                         int'(in_num_valid) - m_acc, $time);
            for (int i = 0; i < m_rem; i++) void'(mq.pop_front());
            for (int i = 0; i < m_acc; i++) mq.push_back(in_packets[i]);
        end
    end

    int c_sz, c_nv;
    always @(negedge clock) begin
        if (model_valid) begin
            c_sz = mq.size();
            c_nv = (c_sz < N) ? c_sz : N;
            check("out_num_valid", 64'(out_num_valid), 64'(c_nv));
            check("free_slots", 64'(free_slots), 64'(DEPTH - c_sz));
            for (int i = 0; i < c_nv; i++)
                check($sformatf("out_packets[%0d]", i), out_packets[i], mq[i]);
        end
    end

    task automatic cyc(input int nin, input logic [31:0] pc0, input int dn,
                       input logic fl, input logic rst);
        in_num_valid  = 2'(nin);
        in_packets[0] = pkt(pc0);
        in_packets[1] = pkt(pc0 + 32'd4);
        dispatch_num  = 2'(dn);
        flush         = fl;
        reset         = rst;
        @(posedge clock);
        #1;
    endtask

    logic [31:0] pc;

    initial begin
        reset = 1'b1; flush = 1'b0; in_num_valid = '0; dispatch_num = '0; in_packets = '0;
        cyc(0, 0, 0, 0, 1);
        cyc(2, 32'h500, 2, 0, 1);
        check("rst_num_valid", 64'(out_num_valid), 64'd0);
        check("rst_free", 64'(free_slots), 64'd8);
        check("rst_out0", out_packets[0], 64'd0);
        check("rst_out1", out_packets[1], 64'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("idle_free", 64'(free_slots), 64'd8);
        check("idle_out0", out_packets[0], 64'd0);

        // Fill to full, then one dropped enqueue
        cyc(2, 32'h00, 0, 0, 0); check("fill1_free", 64'(free_slots), 64'd6);
        check("fill1_head", out_packets[0], pkt(32'h00));
        cyc(2, 32'h08, 0, 0, 0); check("fill2_free", 64'(free_slots), 64'd4);
        cyc(2, 32'h10, 0, 0, 0); check("fill3_free", 64'(free_slots), 64'd2);
        cyc(2, 32'h18, 0, 0, 0); check("fill4_free", 64'(free_slots), 64'd0);
        cyc(2, 32'h20, 0, 0, 0); check("overfill_free", 64'(free_slots), 64'd0);
        check("full_head0", out_packets[0], pkt(32'h00));
        check("full_head1", out_packets[1], pkt(32'h04));

        // Full: simultaneous dispatch does not admit new packets this cycle
        cyc(2, 32'h40, 2, 0, 0);
        check("fulldq_free", 64'(free_slots), 64'd2);
        check("fulldq_head0", out_packets[0], pkt(32'h08));
        check("fulldq_head1", out_packets[1], pkt(32'h0C));

        // Steady 2-in/2-out across pointer wrap
        pc = 32'h100;
        for (int k = 0; k < 20; k++) begin
            cyc(2, pc, 2, 0, 0);
            pc = pc + 32'd8;
        end
        check("wrap_free", 64'(free_slots), 64'd2);
        check("wrap_head0", out_packets[0], pkt(32'h188));
        check("wrap_head1", out_packets[1], pkt(32'h18C));

        // Flush at count 5 overrides same-cycle enqueue/dequeue
        cyc(0, 0, 1, 0, 0);
        check("cnt5_free", 64'(free_slots), 64'd3);
        cyc(2, 32'h200, 2, 1, 0);
        check("flush_num_valid", 64'(out_num_valid), 64'd0);
        check("flush_free", 64'(free_slots), 64'd8);
        cyc(1, 32'h100, 0, 0, 0);
        check("postflush_num", 64'(out_num_valid), 64'd1);
        check("postflush_head", out_packets[0], pkt(32'h100));

        // Over-request from a single entry clamps to empty
        cyc(0, 0, 2, 0, 0);
        check("underflow_num", 64'(out_num_valid), 64'd0);
        check("underflow_free", 64'(free_slots), 64'd8);
        cyc(2, 32'h400, 0, 0, 0);
        check("after_uf_head0", out_packets[0], pkt(32'h400));
        check("after_uf_head1", out_packets[1], pkt(32'h404));

        // Mid-stream reset discards contents and clears storage
        cyc(2, 32'h600, 1, 0, 1);
        check("midrst_num", 64'(out_num_valid), 64'd0);
        check("midrst_free", 64'(free_slots), 64'd8);
        check("midrst_out0", out_packets[0], 64'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
